// File: rtl/rx_demod_decim_if.sv
// rtl/rx_demod_decim_if.sv - sample/LO input, control and averaged I/Q output bundle for rx_demod_decim
interface rx_demod_decim_if #(
    parameter int SAMP     = 4,
    parameter int ADC_BITS = 14,
    parameter int LO_BITS  = 16,
    parameter int OUT_BITS = 16,
    parameter int CNT_BITS = 16
);
    logic [SAMP*ADC_BITS-1:0]    signal_in;
    logic                        in_valid;
    logic [SAMP*LO_BITS-1:0]     lo_i;
    logic [SAMP*LO_BITS-1:0]     lo_q;
    logic [3:0]                  dec_log2;
    logic [CNT_BITS-1:0]         capture_len;
    logic                        arm;
    logic                        abort;
    logic signed [OUT_BITS-1:0]  data_out_i;
    logic signed [OUT_BITS-1:0]  data_out_q;
    logic                        out_valid;
    logic                        busy;
    logic                        done;

    modport master (
        output signal_in, in_valid, lo_i, lo_q, dec_log2, capture_len, arm, abort,
        input  data_out_i, data_out_q, out_valid, busy, done
    );

    modport slave (
        input  signal_in, in_valid, lo_i, lo_q, dec_log2, capture_len, arm, abort,
        output data_out_i, data_out_q, out_valid, busy, done
    );
endinterface

// File: rtl/rx_demod_decim.sv
// rtl/rx_demod_decim.sv - multi-lane I/Q mixer, lane summer and armed boxcar decimator
module rx_demod_decim #(
    parameter int SAMP         = 4,
    parameter int ADC_BITS     = 14,
    parameter int LO_BITS      = 16,
    parameter int OUT_BITS     = 16,
    parameter int MAX_DEC_LOG2 = 8,
    parameter int CNT_BITS     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    rx_demod_decim_if.slave   bus
);
    localparam int P  = ADC_BITS + LO_BITS;
    localparam int LG = $clog2(SAMP);
    localparam int S  = P + LG;
    localparam int A  = S + MAX_DEC_LOG2;
    localparam int WB = MAX_DEC_LOG2 + 1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
    localparam logic [WB-1:0]       WRD_ONE = WB'(1);
    localparam logic [3:0]          DEC_MAX = 4'(MAX_DEC_LOG2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_next;

    logic [3:0]          dec;
    logic [CNT_BITS-1:0] len, blk_cnt;
    logic [WB-1:0]       word_cnt, blk_mask;
    logic                accept, block_last, shot_end;

    logic signed [P-1:0] mul_i [SAMP];
    logic signed [P-1:0] mul_q [SAMP];
    logic signed [P-1:0] prod_i [SAMP];
    logic signed [P-1:0] prod_q [SAMP];
    logic                v1, last1, end1, v2, last2, end2;

    logic signed [S-1:0] sum_i, sum_q, sum2_i, sum2_q;
    logic signed [A-1:0] acc_i, acc_q, tot_i, tot_q, shf_i, shf_q;

    logic signed [OUT_BITS-1:0] out_i, out_q;
    logic                       out_valid_r, done_r;

    for (genvar l = 0; l < SAMP; l++) begin : g_lane
        logic [ADC_BITS-1:0] a;
        logic [LO_BITS-1:0]  ci, cq;
        assign a  = bus.signal_in[l*ADC_BITS +: ADC_BITS];
        assign ci = bus.lo_i[l*LO_BITS +: LO_BITS];
        assign cq = bus.lo_q[l*LO_BITS +: LO_BITS];
        assign mul_i[l] = $signed({{LO_BITS{a[ADC_BITS-1]}}, a}) * $signed({{ADC_BITS{ci[LO_BITS-1]}}, ci});
        assign mul_q[l] = $signed({{LO_BITS{a[ADC_BITS-1]}}, a}) * $signed({{ADC_BITS{cq[LO_BITS-1]}}, cq});
    end

    always_comb begin
        sum_i = '0;
        sum_q = '0;
        for (int l = 0; l < SAMP; l++) begin
            sum_i = sum_i + {{LG{prod_i[l][P-1]}}, prod_i[l]};
            sum_q = sum_q + {{LG{prod_q[l][P-1]}}, prod_q[l]};
        end
    end

    // The block's final word is folded in together with the shift, so the accumulator never holds it
    always_comb begin
        tot_i = acc_i + {{(A-S){sum2_i[S-1]}}, sum2_i};
        tot_q = acc_q + {{(A-S){sum2_q[S-1]}}, sum2_q};
        shf_i = tot_i >>> dec;
        shf_q = tot_q >>> dec;
    end

    assign accept     = bus.in_valid && (state == RUN);
    assign blk_mask   = (WRD_ONE << dec) - WRD_ONE;
    assign block_last = (word_cnt == blk_mask);
    assign shot_end   = block_last && (len != '0) && (blk_cnt == len - CNT_ONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.arm) state_next = RUN;
            RUN:     if (accept && shot_end) state_next = DRAIN;
            DRAIN:   if (v2 && end2) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.abort) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec <= '0; len <= '0; blk_cnt <= '0; word_cnt <= '0;
            v1 <= 1'b0; last1 <= 1'b0; end1 <= 1'b0;
            v2 <= 1'b0; last2 <= 1'b0; end2 <= 1'b0;
            for (int l = 0; l < SAMP; l++) begin
                prod_i[l] <= '0;
                prod_q[l] <= '0;
            end
            sum2_i <= '0; sum2_q <= '0;
            acc_i <= '0; acc_q <= '0;
            out_i <= '0; out_q <= '0;
            out_valid_r <= 1'b0; done_r <= 1'b0;
        end else if (bus.abort) begin
            // Output data registers deliberately keep their last values
            blk_cnt <= '0; word_cnt <= '0;
            v1 <= 1'b0; v2 <= 1'b0;
            acc_i <= '0; acc_q <= '0;
            out_valid_r <= 1'b0; done_r <= 1'b0;
        end else begin
            if (state == IDLE && bus.arm) begin
                dec      <= (bus.dec_log2 > DEC_MAX) ? DEC_MAX : bus.dec_log2;
                len      <= bus.capture_len;
                blk_cnt  <= '0;
                word_cnt <= '0;
            end
            v1 <= accept;
            if (accept) begin
                for (int l = 0; l < SAMP; l++) begin
                    prod_i[l] <= mul_i[l];
                    prod_q[l] <= mul_q[l];
                end
                last1    <= block_last;
                end1     <= shot_end;
                word_cnt <= block_last ? '0 : word_cnt + WRD_ONE;
                if (block_last) blk_cnt <= blk_cnt + CNT_ONE;
            end
            v2 <= v1;
            if (v1) begin
                sum2_i <= sum_i;
                sum2_q <= sum_q;
                last2  <= last1;
                end2   <= end1;
            end
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            if (v2) begin
                if (last2) begin
                    out_i       <= shf_i[S-1 -: OUT_BITS];
                    out_q       <= shf_q[S-1 -: OUT_BITS];
                    acc_i       <= '0;
                    acc_q       <= '0;
                    out_valid_r <= 1'b1;
                    done_r      <= end2;
                end else begin
                    acc_i <= tot_i;
                    acc_q <= tot_q;
                end
            end
        end
    end

    assign bus.data_out_i = out_i;
    assign bus.data_out_q = out_q;
    assign bus.out_valid  = out_valid_r;
    assign bus.done       = done_r;
    assign bus.busy       = (state != IDLE);
endmodule
